// File: rtl/sram_like_data_slave.sv
// Responder for the CPU data-side SRAM-like bus: byte-lane writes into a local word RAM,
// read snapshots at accept, and in-order responses after a fixed latency.
module sram_like_data_slave #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 4,
  parameter int LATENCY  = 2,
  parameter int STALL_EN = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        wen;
  logic              accept;
  logic              stall;
  logic [7:0]        lfsr;

  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [PTR_W:0]    count;
  logic              entryValid [DEPTH];
  logic              entryWr    [DEPTH];
  logic [31:0]       entryData  [DEPTH];
  logic [CNT_W-1:0]  entryCnt   [DEPTH];

  // Address bits above the word index alias onto the same RAM words.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[31:ADDR_W+2];

  assign idx = addr[ADDR_W+1:2];

  always_comb begin
    wen = 4'b0000;
    case (size)
      2'd0:    wen = 4'b0001 << addr[1:0];
      2'd1:    wen = addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    wen = 4'b1111;
      default: wen = (addr[1:0] == 2'd1) ? 4'b1110 : 4'b0111;
    endcase
  end

  assign stall   = (STALL_EN != 0) && (lfsr[1:0] == 2'b00);
  // Fullness is judged on the registered count only; a same-cycle pop does not free a slot.
  assign addr_ok = resetn & req & (count < FULL_CNT) & ~stall;
  assign accept  = req & addr_ok;

  assign data_ok = resetn & entryValid[headPtr] & (entryCnt[headPtr] == '0);
  assign rdata   = (data_ok && !entryWr[headPtr]) ? entryData[headPtr] : 32'h0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // RAM survives reset; accept already requires resetn high.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) entryValid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entryValid[i] && entryCnt[i] != '0) entryCnt[i] <= entryCnt[i] - 1'b1;
      end
      if (data_ok) begin
        entryValid[headPtr] <= 1'b0;
        headPtr             <= headPtr + 1'b1;
      end
      if (accept) begin
        // Snapshot is taken before this edge's write, but only one request lands per edge.
        entryValid[tailPtr] <= 1'b1;
        entryWr[tailPtr]    <= wr;
        entryData[tailPtr]  <= wr ? 32'h0 : mem[idx];
        entryCnt[tailPtr]   <= LAT_INIT;
        tailPtr             <= tailPtr + 1'b1;
      end
      case ({accept, data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Bench for sram_like_data_slave: four instances with different latency/stall settings,
// checked against a word-array memory model and a due-cycle response queue.
module tb_sram_like_data_slave;

  logic        clk;
  logic        resetn [4];
  logic        req    [4];
  logic        wr     [4];
  logic [1:0]  size   [4];
  logic [31:0] addr   [4];
  logic [31:0] wdata  [4];
  logic        addrOk [4];
  logic        dataOk [4];
  logic [31:0] rdata  [4];

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          chk;
  } resp_t;

  sram_like_data_slave #(.ADDR_W(10), .DEPTH(4), .LATENCY(2), .STALL_EN(0)) u0 (
    .clk(clk), .resetn(resetn[0]), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addrOk[0]), .data_ok(dataOk[0]), .rdata(rdata[0]));
  sram_like_data_slave #(.ADDR_W(10), .DEPTH(4), .LATENCY(8), .STALL_EN(0)) u1 (
    .clk(clk), .resetn(resetn[1]), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addrOk[1]), .data_ok(dataOk[1]), .rdata(rdata[1]));
  sram_like_data_slave #(.ADDR_W(10), .DEPTH(4), .LATENCY(1), .STALL_EN(0)) u2 (
    .clk(clk), .resetn(resetn[2]), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
    .wdata(wdata[2]), .addr_ok(addrOk[2]), .data_ok(dataOk[2]), .rdata(rdata[2]));
  sram_like_data_slave #(.ADDR_W(10), .DEPTH(4), .LATENCY(2), .STALL_EN(1)) u3 (
    .clk(clk), .resetn(resetn[3]), .req(req[3]), .wr(wr[3]), .size(size[3]), .addr(addr[3]),
    .wdata(wdata[3]), .addr_ok(addrOk[3]), .data_ok(dataOk[3]), .rdata(rdata[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-range view of a write: first byte and byte count, then copy those bytes.
  function automatic logic [31:0] apply_wr(input logic [31:0] old, input logic [1:0] sz,
                                           input logic [1:0] a, input logic [31:0] d);
    int first, n;
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0: begin first = int'(a);               n = 1; end
      2'd1: begin first = int'(a) & 2;           n = 2; end
      2'd2: begin first = 0;                     n = 4; end
      default: begin first = (a == 2'd1) ? 1 : 0; n = 3; end
    endcase
    for (int b = first; b < first + n; b++) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Single transaction on instance k: waits for accept, then for its response.
  task automatic do_op(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output int lat,
                       output bit ok);
    int t;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; size[k] = sz; addr[k] = a; wdata[k] = d;
    #1;
    t = 0;
    while (!addrOk[k] && t < 100) begin @(negedge clk); #1; t++; end
    ok = addrOk[k]; rd = 32'h0; lat = 0;
    if (!ok) begin req[k] = 1'b0; return; end
    @(negedge clk);
    req[k] = 1'b0;
    lat = 1;
    while (!dataOk[k] && lat < 100) begin @(negedge clk); lat++; end
    ok = dataOk[k]; rd = rdata[k];
  endtask

  logic [31:0] ref0 [1024];
  logic [31:0] ref1 [1024];
  logic [31:0] ref2 [1024];
  logic [31:0] ref3 [16];
  bit          known3 [16];

  task automatic test_reset();
    logic [31:0] rd; int lat; bit ok;
    for (int k = 0; k < 4; k++) begin
      resetn[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0;
      addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    nTests++; if (addrOk[0] !== 1'b0) begin nFail++; $display("FAIL reset_addr_ok got=%b exp=0", addrOk[0]); end
    nTests++; if (dataOk[0] !== 1'b0) begin nFail++; $display("FAIL reset_data_ok got=%b exp=0", dataOk[0]); end
    nTests++; if (rdata[0] !== 32'h0) begin nFail++; $display("FAIL reset_rdata got=%h exp=0", rdata[0]); end
    nTests++; if (u0.count !== 3'd0) begin nFail++; $display("FAIL reset_count got=%0d exp=0", u0.count); end
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) resetn[k] = 1'b1;
    do_op(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat, ok);
    ref0[4] = 32'hDEADBEEF;
    nTests++; if (!ok || lat != 2) begin nFail++; $display("FAIL wr_latency got=%0d ok=%0d exp=2", lat, ok); end
    nTests++; if (rd !== 32'h0) begin nFail++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    do_op(0, 1'b0, 2'd2, 32'h10, 32'h0, rd, lat, ok);
    nTests++; if (!ok || lat != 2) begin nFail++; $display("FAIL rd_latency got=%0d ok=%0d exp=2", lat, ok); end
    nTests++; if (rd !== 32'hDEADBEEF) begin nFail++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_partial();
    logic [31:0] rd, a, d, exp; int lat; bit ok;
    logic [1:0] sz;
    logic [1:0]  szTab [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
    logic [31:0] aTab  [4] = '{32'h20, 32'h23, 32'h21, 32'h21};
    logic [31:0] dTab  [4] = '{32'h11223344, 32'hAA000000, 32'h0000BBCC, 32'h99887700};
    logic [31:0] eTab  [4] = '{32'h11223344, 32'hAA223344, 32'hAA22BBCC, 32'h998877CC};
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b1, szTab[i], aTab[i], dTab[i], rd, lat, ok);
      ref0[8] = apply_wr(ref0[8], szTab[i], aTab[i][1:0], dTab[i]);
      do_op(0, 1'b0, 2'd2, 32'h20, 32'h0, rd, lat, ok);
      nTests++; if (!ok || rd !== eTab[i] || rd !== ref0[8]) begin
        nFail++; $display("FAIL partial_%0d got=%h exp=%h", i, rd, eTab[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(3));
      a  = 32'h20 | 32'($urandom_range(3)) | ($urandom & 32'hFFFF_F000);
      d  = $urandom;
      do_op(0, 1'b1, sz, a, d, rd, lat, ok);
      ref0[8] = apply_wr(ref0[8], sz, a[1:0], d);
      exp = ref0[8];
      do_op(0, 1'b0, 2'($urandom_range(3)), 32'h20 | 32'($urandom_range(3)), 32'h0, rd, lat, ok);
      nTests++; if (!ok || rd !== exp) begin
        nFail++; $display("FAIL partial_rand_%0d size=%0d addr=%h got=%h exp=%h", i, sz, a, rd, exp);
      end
    end
  endtask

  task automatic test_full();
    int q[$]; int acc; int dok; bit expD, expA;
    acc = 0; dok = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      expD = (q.size() > 0 && q[0] == c);
      nTests++; if (dataOk[1] !== expD) begin nFail++; $display("FAIL full_data_ok c=%0d got=%b exp=%b", c, dataOk[1], expD); end
      if (dataOk[1]) dok++;
      req[1] = (acc < 5); wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'(c * 4);
      #1;
      expA = req[1] && q.size() < 4;
      nTests++; if (addrOk[1] !== expA) begin nFail++; $display("FAIL full_addr_ok c=%0d got=%b exp=%b", c, addrOk[1], expA); end
      if (addrOk[1] && req[1]) acc++;
      if (expD) void'(q.pop_front());
      if (expA) q.push_back(c + 8);
    end
    req[1] = 1'b0;
    nTests++; if (acc != 5) begin nFail++; $display("FAIL full_accepts got=%0d exp=5", acc); end
    nTests++; if (dok != 5) begin nFail++; $display("FAIL full_responses got=%0d exp=5", dok); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; bit ok; bit expD; int run; int best;
    resp_t q[$]; resp_t e;
    for (int w = 0; w < 16; w++) begin
      ref2[w + 16] = $urandom;
      do_op(2, 1'b1, 2'd2, 32'((w + 16) * 4), ref2[w + 16], rd, lat, ok);
    end
    nTests++; if (!ok || lat != 1) begin nFail++; $display("FAIL lat1_latency got=%0d exp=1", lat); end
    run = 0; best = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      expD = (q.size() > 0 && q[0].due == c);
      nTests++; if (dataOk[2] !== expD) begin nFail++; $display("FAIL stream_data_ok c=%0d got=%b exp=%b", c, dataOk[2], expD); end
      if (expD) begin
        e = q.pop_front();
        nTests++; if (rdata[2] !== e.data) begin nFail++; $display("FAIL stream_rdata c=%0d got=%h exp=%h", c, rdata[2], e.data); end
      end
      run = dataOk[2] ? run + 1 : 0;
      if (run > best) best = run;
      req[2] = (c < 16); wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 32'((c + 16) * 4);
      #1;
      nTests++; if (addrOk[2] !== req[2]) begin nFail++; $display("FAIL stream_addr_ok c=%0d got=%b exp=%b", c, addrOk[2], req[2]); end
      if (req[2]) begin e.due = c + 1; e.data = ref2[c + 16]; e.chk = 1'b1; q.push_back(e); end
    end
    req[2] = 1'b0;
    nTests++; if (best != 16) begin nFail++; $display("FAIL stream_run got=%0d exp=16", best); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; int lat; bit ok; int seen;
    for (int w = 0; w < 3; w++) begin
      ref1[40 + w] = $urandom;
      do_op(1, 1'b1, 2'd2, 32'((40 + w) * 4), ref1[40 + w], rd, lat, ok);
    end
    nTests++; if (!ok || lat != 8) begin nFail++; $display("FAIL lat8_latency got=%0d exp=8", lat); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'((40 + c) * 4);
    end
    @(negedge clk);
    req[1] = 1'b0;
    nTests++; if (u1.count !== 3'd3) begin nFail++; $display("FAIL mid_count_before got=%0d exp=3", u1.count); end
    resetn[1] = 1'b0;
    @(negedge clk);
    resetn[1] = 1'b1;
    nTests++; if (u1.count !== 3'd0) begin nFail++; $display("FAIL mid_count_after got=%0d exp=0", u1.count); end
    seen = 0;
    repeat (12) begin @(negedge clk); if (dataOk[1]) seen++; end
    nTests++; if (seen != 0) begin nFail++; $display("FAIL mid_stale_data_ok got=%0d exp=0", seen); end
    for (int w = 0; w < 3; w++) begin
      do_op(1, 1'b0, 2'd2, 32'((40 + w) * 4), 32'h0, rd, lat, ok);
      nTests++; if (!ok || rd !== ref1[40 + w]) begin nFail++; $display("FAIL mid_ram_kept w=%0d got=%h exp=%h", w, rd, ref1[40 + w]); end
    end
  endtask

  task automatic test_stall_random();
    resp_t q[$]; resp_t e;
    logic [7:0] mLfsr; bit expD, expA; int acc; int w; int c; int errs;
    for (int i = 0; i < 16; i++) known3[i] = 1'b0;
    @(negedge clk);
    resetn[3] = 1'b0; req[3] = 1'b0;
    @(negedge clk);
    resetn[3] = 1'b1;
    mLfsr = 8'hA5; acc = 0; c = 0; errs = 0;
    while (c < 3000 && (acc < 200 || q.size() > 0)) begin
      expD = (q.size() > 0 && q[0].due == c);
      nTests++; if (dataOk[3] !== expD) begin nFail++; errs++; $display("FAIL stall_data_ok c=%0d got=%b exp=%b", c, dataOk[3], expD); end
      if (expD) begin
        e = q.pop_front();
        nTests++; if (e.chk && rdata[3] !== e.data) begin nFail++; errs++; $display("FAIL stall_rdata c=%0d got=%h exp=%h", c, rdata[3], e.data); end
      end
      w = int'($urandom_range(15));
      req[3]   = (acc < 200) && ($urandom_range(9) < 7);
      wr[3]    = 1'($urandom_range(1));
      size[3]  = 2'($urandom_range(3));
      addr[3]  = ($urandom & 32'hFFFF_F003) | 32'(w << 2);
      wdata[3] = $urandom;
      #1;
      expA = req[3] && q.size() < 4 && mLfsr[1:0] != 2'b00;
      nTests++; if (addrOk[3] !== expA) begin nFail++; errs++; $display("FAIL stall_addr_ok c=%0d lfsr=%h got=%b exp=%b", c, mLfsr, addrOk[3], expA); end
      if (expA) begin
        acc++;
        e.due = c + 2;
        if (wr[3]) begin
          ref3[w] = apply_wr(ref3[w], size[3], addr[3][1:0], wdata[3]);
          if (size[3] == 2'd2) known3[w] = 1'b1;
          e.data = 32'h0; e.chk = 1'b1;
        end else begin
          e.data = ref3[w]; e.chk = known3[w];
        end
        q.push_back(e);
      end
      mLfsr = lfsr_next(mLfsr);
      if (errs > 20) break;
      @(negedge clk);
      c++;
    end
    req[3] = 1'b0;
    nTests++; if (acc != 200 || q.size() != 0) begin nFail++; $display("FAIL stall_completion accepts=%0d pending=%0d exp=200/0", acc, q.size()); end
  endtask

  initial begin
    test_reset();
    test_partial();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    test_stall_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
